seq_alu: RTL and testbench

Parametrised, registered ALU for the datapath: the execute-stage successor to the single-cycle combinational ALU. It handles all existing move/arithmetic/logic/shift operations in one cycle, and adds iterative unsigned multiply, divide and remainder over several cycles. Results are qualified by a start/busy/done handshake and carry a condition-flag vector. It sits between the register-file read ports (`sr`, `tr`) and the write-back path (`dr`, `we`).

---
 rtl/seq_alu.sv | 203 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Registered ALU: ops 0-12 and divide-by-zero finish in one cycle. MUL/DIVU/REMU
// iterate for WIDTH cycles (IDLE | accepts start, RUN | one shift-add or restoring-subtract step per cycle).
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SA_W  = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [SA_W-1:0]  sa_i,
  input  logic [WIDTH-1:0] sr_i,
  input  logic [WIDTH-1:0] tr_i,
  output logic [WIDTH-1:0] dr_o,
  output logic             we_o,
  output logic [3:0]       flags_o,
  output logic             div_zero_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam logic [3:0] OP_MOV = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NEG  = 4'd7;
  localparam logic [3:0] OP_NOT = 4'd8,  OP_SLL = 4'd9,  OP_SLA = 4'd10, OP_SRL  = 4'd11;
  localparam logic [3:0] OP_SRA = 4'd12, OP_MUL = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15;
  localparam logic [1:0] MOP_MUL = 2'b01, MOP_REM = 2'b11;
  localparam int CNT_W = SA_W + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, dvs_q, dvs_d, dr_q, dr_d;
  logic [1:0]       mop_q, mop_d;
  logic [3:0]       flags_q, flags_d;
  logic             we_q, we_d, dz_q, dz_d, done_q, done_d;

  logic [WIDTH-1:0] alu_res, sla_back, mc_res;
  logic [WIDTH:0]   ext_s, mul_sum, trial;
  logic             alu_c, alu_v, alu_we, alu_dz, qbit, mc_cv, start_mc;

  // Single-cycle datapath; shifts use a one-bit extension to catch the last bit out.
  always_comb begin
    ext_s    = '0;
    sla_back = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_we   = 1'b1;
    alu_dz   = 1'b0;
    case (op_i)
      OP_MOV: alu_res = sr_i;
      OP_ADD: begin
        ext_s   = {1'b0, tr_i} + {1'b0, sr_i};
        alu_res = ext_s[WIDTH-1:0];
        alu_c   = ext_s[WIDTH];
        alu_v   = (tr_i[WIDTH-1] == sr_i[WIDTH-1]) && (alu_res[WIDTH-1] != tr_i[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        ext_s   = {1'b0, tr_i} - {1'b0, sr_i};
        alu_res = ext_s[WIDTH-1:0];
        alu_c   = ext_s[WIDTH];
        alu_v   = (tr_i[WIDTH-1] != sr_i[WIDTH-1]) && (alu_res[WIDTH-1] != tr_i[WIDTH-1]);
        alu_we  = (op_i != OP_CMP);
      end
      OP_AND: alu_res = tr_i & sr_i;
      OP_OR:  alu_res = tr_i | sr_i;
      OP_XOR: alu_res = tr_i ^ sr_i;
      OP_NEG: begin
        alu_res = -tr_i;
        alu_c   = |tr_i;
        alu_v   = tr_i[WIDTH-1] & alu_res[WIDTH-1];
      end
      OP_NOT: alu_res = ~tr_i;
      OP_SLL, OP_SLA: begin
        ext_s   = {1'b0, tr_i} << sa_i;
        alu_res = ext_s[WIDTH-1:0];
        alu_c   = ext_s[WIDTH];
        if (op_i == OP_SLA) begin
          // Shifting back arithmetically recovers tr only if no sign change occurred.
          sla_back = $signed(alu_res) >>> sa_i;
          alu_v    = (sla_back != tr_i);
        end
      end
      OP_SRL: begin
        ext_s   = {tr_i, 1'b0} >> sa_i;
        alu_res = ext_s[WIDTH:1];
        alu_c   = ext_s[0];
      end
      OP_SRA: begin
        ext_s   = $signed({tr_i, 1'b0}) >>> sa_i;
        alu_res = ext_s[WIDTH:1];
        alu_c   = ext_s[0];
      end
      OP_DIVU: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REMU: begin
        alu_res = tr_i;
        alu_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      mop_q   <= '0;
      dr_q    <= '0;
      flags_q <= '0;
      we_q    <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      mop_q   <= mop_d;
      dr_q    <= dr_d;
      flags_q <= flags_d;
      we_q    <= we_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    mop_d   = mop_q;
    dr_d    = dr_q;
    flags_d = flags_q;
    we_d    = we_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    mc_res  = '0;
    mc_cv   = 1'b0;
    start_mc = (op_i >= OP_MUL) && ((op_i == OP_MUL) || (sr_i != '0));
    mul_sum = {1'b0, hi_q} + ({1'b0, dvs_q} & {(WIDTH+1){lo_q[0]}});
    trial   = {hi_q, lo_q[WIDTH-1]};
    qbit    = (trial >= {1'b0, dvs_q});
    case (state_q)
      S_IDLE: begin
        if (start_i && start_mc) begin
          state_d = S_RUN;
          cnt_d   = CNT_INIT;
          hi_d    = '0;
          lo_d    = tr_i;
          dvs_d   = sr_i;
          mop_d   = op_i[1:0];
        end else if (start_i) begin
          dr_d    = alu_res;
          flags_d = {alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v};
          we_d    = alu_we;
          dz_d    = alu_dz;
          done_d  = 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (mop_q == MOP_MUL) begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = qbit ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], qbit};
        end
        if (cnt_q == CNT_ONE) begin
          mc_res  = (mop_q == MOP_REM) ? hi_d : lo_d;
          mc_cv   = (mop_q == MOP_MUL) && (hi_d != '0);
          state_d = S_IDLE;
          dr_d    = mc_res;
          flags_d = {mc_res[WIDTH-1], ~|mc_res, mc_cv, mc_cv};
          we_d    = 1'b1;
          dz_d    = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == S_RUN);
    done_o     = done_q;
    dr_o       = dr_q;
    flags_o    = flags_q;
    we_o       = we_q;
    div_zero_o = dz_q;
  end
endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded random/directed bench for seq_alu at WIDTH=32 and WIDTH=8.
`timescale 1ns/1ps
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  logic        start_a = 1'b0;
  logic [3:0]  op_a = '0;
  logic [4:0]  sa_a = '0;
  logic [31:0] sr_a = '0, tr_a = '0, dr_a;
  logic [3:0]  fl_a;
  logic        we_a, dz_a, busy_a, done_a;

  logic        start_b = 1'b0;
  logic [3:0]  op_b = '0;
  logic [2:0]  sa_b = '0;
  logic [7:0]  sr_b = '0, tr_b = '0, dr_b;
  logic [3:0]  fl_b;
  logic        we_b, dz_b, busy_b, done_b;

  seq_alu #(.WIDTH(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .op_i(op_a), .sa_i(sa_a),
    .sr_i(sr_a), .tr_i(tr_a), .dr_o(dr_a), .we_o(we_a), .flags_o(fl_a),
    .div_zero_o(dz_a), .busy_o(busy_a), .done_o(done_a));

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .op_i(op_b), .sa_i(sa_b),
    .sr_i(sr_b), .tr_i(tr_b), .dr_o(dr_b), .we_o(we_b), .flags_o(fl_b),
    .div_zero_o(dz_b), .busy_o(busy_b), .done_o(done_b));

  typedef struct {
    logic [31:0] dr;
    logic [3:0]  flags;
    logic        we;
    logic        dz;
    int          lat;
    int          due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int busy_until_a = 0, run_lo_a = 1, run_hi_a = 0;
  int busy_until_b = 0, run_lo_b = 1, run_hi_b = 0;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic bitof(longint unsigned x, int i);
    return x[i];
  endfunction

  // Reference behaviour from the arithmetic rules; lat=0 means result right after the sampling edge.
  function automatic exp_t model(int w, int op, int sa, longint unsigned sr, longint unsigned tr);
    exp_t e;
    longint unsigned mask, t, s, r, p, full;
    longint signed ts;
    logic c, v, sg;
    mask = (64'd1 << w) - 64'd1;
    t = tr & mask;
    s = sr & mask;
    sg = bitof(t, w - 1);
    c = 1'b0; v = 1'b0; r = 0;
    e.we = 1'b1; e.dz = 1'b0; e.lat = 0; e.due = 0;
    case (op)
      0: r = s;
      1: begin
        full = t + s; r = full & mask; c = bitof(full, w);
        v = (sg == bitof(s, w - 1)) && (bitof(r, w - 1) != sg);
      end
      2, 3: begin
        r = (t - s) & mask; c = (t < s);
        v = (sg != bitof(s, w - 1)) && (bitof(r, w - 1) != sg);
        e.we = (op != 3);
      end
      4: r = t & s;
      5: r = t | s;
      6: r = t ^ s;
      7: begin r = (0 - t) & mask; c = (t != 0); v = (t == (64'd1 << (w - 1))); end
      8: r = ~t & mask;
      9, 10: begin
        r = (t << sa) & mask;
        c = (sa == 0) ? 1'b0 : bitof(t, w - sa);
        if (op == 10) begin
          for (int i = w - sa; i < w; i++) if (bitof(t, i) != sg) v = 1'b1;
          if (bitof(r, w - 1) != sg) v = 1'b1;
        end
      end
      11, 12: begin
        if (op == 11) r = t >> sa;
        else begin
          ts = sg ? (longint'(t) - longint'(64'd1 << w)) : longint'(t);
          r = longint'(ts >>> sa);
          r = r & mask;
        end
        c = (sa == 0) ? 1'b0 : bitof(t, sa - 1);
      end
      13: begin
        p = t * s; r = p & mask; c = ((p >> w) != 0); v = c; e.lat = w;
      end
      default: begin
        if (s == 0) begin
          r = (op == 14) ? mask : t; e.dz = 1'b1;
        end else begin
          r = (op == 14) ? (t / s) : (t % s); e.lat = w;
        end
      end
    endcase
    e.dr = r[31:0];
    e.flags = {bitof(r, w - 1), (r == 0), c, v};
    return e;
  endfunction

  task automatic idle(int n);
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (n) begin
      op_a = 4'($urandom()); sr_a = $urandom(); tr_a = $urandom();
      op_b = 4'($urandom()); sr_b = 8'($urandom()); tr_b = 8'($urandom());
      @(posedge clk); #1;
    end
  endtask

  task automatic issue(int w, int op, int sa, longint unsigned sr, longint unsigned tr);
    exp_t e;
    e = model(w, op, sa, sr, tr);
    if (w == 32) begin
      start_a = 1'b1; op_a = 4'(op); sa_a = 5'(sa); sr_a = 32'(sr); tr_a = 32'(tr);
    end else begin
      start_b = 1'b1; op_b = 4'(op); sa_b = 3'(sa); sr_b = 8'(sr); tr_b = 8'(tr);
    end
    @(posedge clk); #1;
    e.due = cyc + e.lat;
    if (w == 32) begin
      if (cyc > busy_until_a) begin
        qa.push_back(e);
        if (e.lat > 0) begin run_lo_a = cyc; run_hi_a = cyc + e.lat - 1; end
        busy_until_a = cyc + e.lat;
      end
    end else begin
      if (cyc > busy_until_b) begin
        qb.push_back(e);
        if (e.lat > 0) begin run_lo_b = cyc; run_hi_b = cyc + e.lat - 1; end
        busy_until_b = cyc + e.lat;
      end
    end
  endtask

  task automatic wait_free(int w);
    int n;
    n = 0;
    idle(0);
    while (((w == 32) ? (cyc < busy_until_a) : (cyc < busy_until_b)) && n < 100) begin
      idle(1);
      n++;
    end
  endtask

  task automatic rand_op(int w);
    int op, sa;
    longint unsigned m, sr, tr;
    m = (64'd1 << w) - 64'd1;
    op = int'($urandom_range(0, 15));
    sa = int'($urandom_range(0, w - 1));
    tr = longint'($urandom()) & m;
    sr = longint'($urandom()) & m;
    case ($urandom_range(0, 7))
      0: sr = 0;
      1: sr = longint'($urandom_range(1, 15));
      2: tr = m;
      3: tr = 64'd1 << (w - 1);
      default: ;
    endcase
    issue(w, op, sa, sr, tr);
    if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (!rst) begin
      check("busy32", 64'(busy_a), 64'(cyc >= run_lo_a && cyc <= run_hi_a));
      if (done_a) begin
        if (qa.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL done32_spurious: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = qa.pop_front();
          check("dr32", 64'(dr_a), 64'(e.dr));
          check("flags32", 64'(fl_a), 64'(e.flags));
          check("we32", 64'(we_a), 64'(e.we));
          check("divzero32", 64'(dz_a), 64'(e.dz));
          check("latency32", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (!rst) begin
      check("busy8", 64'(busy_b), 64'(cyc >= run_lo_b && cyc <= run_hi_b));
      if (done_b) begin
        if (qb.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL done8_spurious: got done=1, expected none (cycle %0d)", cyc);
        end else begin
          e = qb.pop_front();
          check("dr8", 64'(dr_b), 64'(e.dr));
          check("flags8", 64'(fl_b), 64'(e.flags));
          check("we8", 64'(we_b), 64'(e.we));
          check("divzero8", 64'(dz_b), 64'(e.dz));
          check("latency8", 64'(cyc), 64'(e.due));
        end
      end
    end
  end

  task automatic check_zero_outputs(string tag);
    check({tag, "_dr"}, 64'(dr_a), 64'd0);
    check({tag, "_flags"}, 64'(fl_a), 64'd0);
    check({tag, "_we_dz"}, 64'({we_a, dz_a}), 64'd0);
    check({tag, "_busy_done"}, 64'({busy_a, done_a}), 64'd0);
    check({tag, "_dr8"}, 64'(dr_b), 64'd0);
    check({tag, "_ctl8"}, 64'({fl_b, we_b, dz_b, busy_b, done_b}), 64'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;
    idle(2);

    issue(32, 1, 0, 2, 1);
    issue(32, 2, 0, 3, 5);
    issue(32, 4, 0, 11, 6);
    issue(32, 6, 0, 15, 5);
    issue(32, 7, 0, 0, 15);
    issue(32, 8, 0, 0, 15);
    issue(32, 9, 3, 0, 5);
    issue(32, 11, 3, 0, 64'hFFFFFFD8);
    issue(32, 12, 3, 0, 64'hFFFFFFD8);
    issue(32, 10, 2, 0, 64'h40000001);
    issue(32, 1, 0, 1, 64'h7FFFFFFF);
    issue(32, 3, 0, 6, 2);
    issue(32, 2, 0, 7, 7);
    issue(32, 0, 0, 64'hA5A5A5A5, 0);
    issue(32, 14, 0, 0, 5);
    issue(32, 15, 0, 0, 9);
    wait_free(32);
    issue(32, 13, 0, 64'h10000, 64'h10000);
    wait_free(32);
    issue(32, 13, 0, 6, 7);
    wait_free(32);
    issue(32, 14, 0, 7, 100);
    wait_free(32);
    issue(32, 15, 0, 7, 100);
    wait_free(32);
    issue(32, 13, 0, 9, 9);
    issue(32, 1, 0, 1, 1);
    issue(32, 14, 0, 3, 1000);
    idle(3);
    wait_free(32);
    issue(32, 14, 0, 3, 1000);
    idle(32);
    issue(32, 6, 0, 64'hFF, 64'hF0F0);
    wait_free(32);

    issue(32, 13, 0, 12345, 678);
    idle(10);
    rst = 1'b1;
    qa.delete(); qb.delete();
    busy_until_a = 0; run_lo_a = 1; run_hi_a = 0;
    busy_until_b = 0; run_lo_b = 1; run_hi_b = 0;
    #1;
    check_zero_outputs("midrun_reset");
    idle(2);
    rst = 1'b0;
    idle(40);

    for (int i = 0; i < 400; i++) rand_op(32);

    wait_free(8);
    issue(8, 13, 0, 17, 15);
    wait_free(8);
    issue(8, 12, 7, 0, 8'h80);
    issue(8, 1, 0, 1, 8'hFF);
    issue(8, 10, 3, 0, 8'h1F);
    for (int i = 0; i < 150; i++) rand_op(8);

    idle(1);
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 200) begin
      idle(1);
      n++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_assert++; n_fail++;
      $display("FAIL drain: got %0d results outstanding, expected 0", qa.size() + qb.size());
    end
    idle(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
